// File: rtl/cby_pkg.sv
// Shared types and elaboration-time helpers for the CBY connection block.
package cby_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } cby_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) res = k + 1;
        end
        return res;
    endfunction

    // Even mux inputs tap the bottom side, odd ones the top side of the same track.
    function automatic int track_idx(input int i, input int j, input int chan_w, input int tap_stride);
        return (i + (j / 2) * tap_stride) % chan_w;
    endfunction

endpackage

// File: rtl/cby_ipin_mux.sv
// One grid-pin input mux; drives 0 when disabled or when the select is out of range.
module cby_ipin_mux
    import cby_pkg::*;
#(
    parameter int MUX_SIZE = 6,
    localparam int SEL_W = clog2(MUX_SIZE)
) (
    input  logic [MUX_SIZE-1:0] in,
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic                out
);

    always_comb begin
        out = 1'b0;
        for (int k = 0; k < MUX_SIZE; k++) begin
            if (en && (sel == SEL_W'(k))) out = in[k];
        end
    end

endmodule

// File: rtl/cby_chain_param.sv
// Parametrised Y connection block with serial config chain and commit handshake.
// Define CBY_SHADOW_EN to keep the active configuration in a shadow register during reloads.
//
// state | meaning
// IDLE  | no bits shifted since last commit/reset
// LOAD  | partial load in progress
// READY | full word shifted, commit will be accepted
module cby_chain_param
    import cby_pkg::*;
#(
    parameter int CHAN_W     = 9,
    parameter int NUM_IPIN   = 4,
    parameter int MUX_SIZE   = 6,
    parameter int TAP_STRIDE = 4
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic                cfg_full,
    output logic                cfg_valid,
    output logic                cfg_err,
    input  logic [CHAN_W-1:0]   chany_bottom_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    output logic [CHAN_W-1:0]   chany_top_out,
    output logic [CHAN_W-1:0]   chany_bottom_out,
    output logic [NUM_IPIN-1:0] ipin_out
);

    localparam int SEL_W    = clog2(MUX_SIZE);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;
    localparam int CNT_W    = clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    cby_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] sr_q;
    logic [CFG_BITS-1:0] cfg;
    logic                valid_q;
    logic                err_q;
    logic                shift_acc, commit_ok, commit_rej;

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    // A commit request always swallows a same-cycle shift.
    assign shift_acc  = ccff_en && !cfg_commit;
    assign commit_ok  = cfg_commit && (state_q == READY);
    assign commit_rej = cfg_commit && (state_q != READY);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (commit_ok) begin
            cnt_d = '0;
        end else if (shift_acc && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE, LOAD: begin
                if (shift_acc) state_d = (cnt_d == CNT_FULL) ? READY : LOAD;
            end
            READY: begin
                if (commit_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            sr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (shift_acc) sr_q <= {sr_q[CFG_BITS-2:0], ccff_head};
            err_q <= commit_rej;
        end
    end

`ifdef CBY_SHADOW_EN
    logic [CFG_BITS-1:0] shadow_q;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shadow_q <= '0;
            valid_q  <= 1'b0;
        end else if (commit_ok) begin
            shadow_q <= sr_q;
            valid_q  <= 1'b1;
        end
    end

    assign cfg = shadow_q;
`else
    // Muxes read the shift register directly, so any shift invalidates them.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            valid_q <= 1'b0;
        end else if (commit_ok) begin
            valid_q <= 1'b1;
        end else if (shift_acc) begin
            valid_q <= 1'b0;
        end
    end

    assign cfg = sr_q;
`endif

    assign ccff_tail = sr_q[CFG_BITS-1];
    assign cfg_full  = (state_q == READY);
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
        logic [MUX_SIZE-1:0] mux_in;
        for (genvar j = 0; j < MUX_SIZE; j++) begin : g_tap
            localparam int TRK = track_idx(i, j, CHAN_W, TAP_STRIDE);
            if (j % 2 == 0) begin : g_bot
                assign mux_in[j] = chany_bottom_in[TRK];
            end else begin : g_top
                assign mux_in[j] = chany_top_in[TRK];
            end
        end
        cby_ipin_mux #(.MUX_SIZE(MUX_SIZE)) u_mux (
            .in  (mux_in),
            .sel (cfg[i*SEL_W +: SEL_W]),
            .en  (valid_q),
            .out (ipin_out[i])
        );
    end

endmodule

// File: tb/tb_cby_chain_param.sv
// Self-checking bench for cby_chain_param against a behavioural chain/mux model.
module tb_cby_chain_param;

    localparam int CHAN_W   = 9;
    localparam int NUM_IPIN = 4;
    localparam int CFG_BITS = 12;

    logic                prog_clk = 1'b0;
    logic                prog_reset, ccff_head, ccff_en, cfg_commit;
    logic                ccff_tail, cfg_full, cfg_valid, cfg_err;
    logic [CHAN_W-1:0]   chany_bottom_in, chany_top_in;
    logic [CHAN_W-1:0]   chany_top_out, chany_bottom_out;
    logic [NUM_IPIN-1:0] ipin_out;

    int n_checks = 0;
    int n_errs   = 0;

    // model state
    logic [11:0] m_sr, m_cfg;
    int          m_cnt;
    bit          m_valid, m_err;

    cby_chain_param dut (
        .prog_clk         (prog_clk),
        .prog_reset       (prog_reset),
        .ccff_head        (ccff_head),
        .ccff_en          (ccff_en),
        .cfg_commit       (cfg_commit),
        .ccff_tail        (ccff_tail),
        .cfg_full         (cfg_full),
        .cfg_valid        (cfg_valid),
        .cfg_err          (cfg_err),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_in     (chany_top_in),
        .chany_top_out    (chany_top_out),
        .chany_bottom_out (chany_bottom_out),
        .ipin_out         (ipin_out)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_ipin(input logic [11:0] cfg, input bit valid,
                                            input logic [8:0] bot, input logic [8:0] top);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int sel, trk;
            sel = int'((cfg >> (3 * i)) & 12'h7);
            if (valid && sel < 6) begin
                trk  = (i + (sel / 2) * 4) % 9;
                r[i] = (sel % 2 == 0) ? bot[trk] : top[trk];
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] active_cfg();
`ifdef CBY_SHADOW_EN
        return m_cfg;
`else
        return m_sr;
`endif
    endfunction

    task automatic model_edge();
        if (prog_reset) begin
            m_sr = '0; m_cfg = '0; m_cnt = 0; m_valid = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (cfg_commit) begin
                if (m_cnt == CFG_BITS) begin
                    m_cfg   = m_sr;
                    m_valid = 1;
                    m_cnt   = 0;
                end else begin
                    m_err = 1;
                end
            end else if (ccff_en) begin
                m_sr = {m_sr[10:0], ccff_head};
                if (m_cnt < CFG_BITS) m_cnt++;
`ifndef CBY_SHADOW_EN
                m_valid = 0;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tail"},  32'(ccff_tail), 32'(m_sr[11]));
        check({tag, ".full"},  32'(cfg_full),  32'(m_cnt == CFG_BITS));
        check({tag, ".valid"}, 32'(cfg_valid), 32'(m_valid));
        check({tag, ".err"},   32'(cfg_err),   32'(m_err));
        check({tag, ".ipin"},  32'(ipin_out),
              32'(exp_ipin(active_cfg(), m_valid, chany_bottom_in, chany_top_in)));
        check({tag, ".top_out"}, 32'(chany_top_out),    32'(chany_bottom_in));
        check({tag, ".bot_out"}, 32'(chany_bottom_out), 32'(chany_top_in));
    endtask

    task automatic tick(input string tag);
        @(posedge prog_clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        ccff_en = 0; cfg_commit = 0; ccff_head = 0;
    endtask

    // Shifts value[n-1] first so value[0] ends up in the LSB of ipin 0.
    task automatic shift_word(input logic [15:0] value, input int n, input string tag);
        for (int b = n - 1; b >= 0; b--) begin
            ccff_en = 1; ccff_head = value[b];
            tick(tag);
        end
        idle_inputs();
    endtask

    task automatic commit(input bit with_en, input string tag);
        cfg_commit = 1; ccff_en = with_en; ccff_head = 1'($urandom);
        tick(tag);
        idle_inputs();
    endtask

    task automatic do_reset();
        prog_reset = 1;
        tick("reset");
        tick("reset");
        prog_reset = 0;
    endtask

    initial begin
        logic [11:0] w;
        prog_reset = 1; idle_inputs();
        chany_bottom_in = '0; chany_top_in = '0;
        m_sr = '0; m_cfg = '0; m_cnt = 0; m_valid = 0; m_err = 0;
        do_reset();

        chany_bottom_in = 9'h1A5;
        #1;
        check("pass_through", 32'(chany_top_out), 32'h1A5);
        check("reset_ipin", 32'(ipin_out), 32'h0);
        tick("post_reset");

        // ipin0 sel=2 -> bottom track 4; ipin1 sel=0 -> bottom track 1
        shift_word(16'h002, 12, "load_002");
        commit(0, "commit_002");
        chany_bottom_in = 9'h010; chany_top_in = '0;
        #1;
        check("ipin0_bot4", 32'(ipin_out[0]), 32'h1);
        tick("bot4");
        chany_bottom_in = 9'h002;
        #1;
        check("ipin1_bot1", 32'(ipin_out[1]), 32'h1);
        tick("bot1");

        // premature commit after 7 shifts
        do_reset();
        shift_word(16'h055, 7, "partial7");
        commit(0, "reject7");
        check("reject_err", 32'(cfg_err), 32'h1);
        tick("reject_after");
        shift_word(16'h01F, 5, "finish12");
        check("full_after_12", 32'(cfg_full), 32'h1);

        // out-of-range select on ipin 2
        w = 12'h1C0 | 12'(($urandom & 32'h3F) | (($urandom & 32'h3) << 9));
        shift_word(16'(w), 12, "load_sel7");
        commit(0, "commit_sel7");
        for (int k = 0; k < 8; k++) begin
            chany_bottom_in = 9'($urandom); chany_top_in = 9'($urandom);
            #1;
            check("ipin2_oor", 32'(ipin_out[2]), 32'h0);
            tick("sel7_tracks");
        end

        // overlong load, commit with a concurrent shift
        shift_word(16'($urandom), 13, "load13");
        check("full_13", 32'(cfg_full), 32'h1);
        commit(1, "commit_with_en");

        // reload while a configuration is active, then reset mid-load
        chany_bottom_in = 9'($urandom); chany_top_in = 9'($urandom);
        shift_word(16'($urandom), 1, "reload1");
        shift_word(16'($urandom), 4, "reload5");
        prog_reset = 1;
        tick("mid_reset");
        prog_reset = 0;
        check("mid_reset_valid", 32'(cfg_valid), 32'h0);
        check("mid_reset_tail", 32'(ccff_tail), 32'h0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            ccff_en    = ($urandom_range(3, 0) != 0);
            cfg_commit = ($urandom_range(9, 0) == 0);
            ccff_head  = 1'($urandom);
            prog_reset = ($urandom_range(150, 0) == 0);
            chany_bottom_in = 9'($urandom); chany_top_in = 9'($urandom);
            tick("random");
        end
        idle_inputs(); prog_reset = 0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
